ex_stage: RTL and testbench

//  Execute stage fed directly by the ID/EX pipeline register. Computes the ALU result,

---
 rtl/ex_stage.sv | 264 ++++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the pipeline.
//
// Computes the ALU result for RV32I ALU ops and RV32M multiply (single cycle) and
// divide/remainder (iterative restoring division, one quotient bit per cycle).
// Holds the EX/MEM pipeline register that feeds the memory stage.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   alu_1_opr_i, alu_2_opr_i   ALU operands A and B
//   alu_op_i, alu_flag_i       operation code and SUB/SRA variant select
//   advance_pc_i .. reg_src_i  instruction fields carried to the memory stage
//   stall_o                    1 = upstream must hold every *_i stable
//   *_o (remaining)            EX/MEM pipeline register outputs
module ex_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] alu_1_opr_i,
    input  logic [XLEN-1:0] alu_2_opr_i,
    input  logic [3:0]      alu_op_i,
    input  logic            alu_flag_i,
    input  logic [XLEN-1:0] advance_pc_i,
    input  logic [XLEN-1:0] reg_2_data_i,
    input  logic            reg_write_i,
    input  logic [4:0]      reg_write_data_addr_i,
    input  logic            mem_write_i,
    input  logic [1:0]      mem_width_i,
    input  logic            mem_sign_extend_i,
    input  logic [1:0]      reg_src_i,
    output logic            stall_o,
    output logic [XLEN-1:0] alu_result_o,
    output logic [XLEN-1:0] advance_pc_o,
    output logic [XLEN-1:0] reg_2_data_o,
    output logic            reg_write_o,
    output logic [4:0]      reg_write_data_addr_o,
    output logic            mem_write_o,
    output logic [1:0]      mem_width_o,
    output logic            mem_sign_extend_o,
    output logic [1:0]      reg_src_o
);

    localparam int unsigned ShW  = $clog2(XLEN);
    localparam int unsigned CntW = ShW + 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e state_q, state_d;

    // ------------------------------------------------------------------------
    // Single-cycle ALU and multiplier
    // ------------------------------------------------------------------------
    logic [ShW-1:0]    shamt;
    logic [XLEN-1:0]   alu_res;
    logic              mul_a_signed;
    logic              mul_b_signed;
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] product;
    logic              is_div;

    assign shamt  = alu_2_opr_i[ShW-1:0];
    assign is_div = (alu_op_i[3:2] == 2'b11);

    // Sign-extending both operands to 2*XLEN makes one truncated multiply cover
    // MUL, MULH, MULHSU and MULHU.
    assign mul_a_signed = (alu_op_i == 4'd9) || (alu_op_i == 4'd10);
    assign mul_b_signed = (alu_op_i == 4'd9);
    assign mul_a   = {{XLEN{mul_a_signed & alu_1_opr_i[XLEN-1]}}, alu_1_opr_i};
    assign mul_b   = {{XLEN{mul_b_signed & alu_2_opr_i[XLEN-1]}}, alu_2_opr_i};
    assign product = mul_a * mul_b;

    always_comb begin
        alu_res = '0;
        case (alu_op_i)
            4'd0:  alu_res = alu_flag_i ? alu_1_opr_i - alu_2_opr_i
                                        : alu_1_opr_i + alu_2_opr_i;
            4'd1:  alu_res = alu_1_opr_i << shamt;
            4'd2:  alu_res = {{(XLEN-1){1'b0}},
                              ($signed(alu_1_opr_i) < $signed(alu_2_opr_i))};
            4'd3:  alu_res = {{(XLEN-1){1'b0}}, (alu_1_opr_i < alu_2_opr_i)};
            4'd4:  alu_res = alu_1_opr_i ^ alu_2_opr_i;
            4'd5:  alu_res = alu_flag_i ? XLEN'($signed(alu_1_opr_i) >>> shamt)
                                        : alu_1_opr_i >> shamt;
            4'd6:  alu_res = alu_1_opr_i | alu_2_opr_i;
            4'd7:  alu_res = alu_1_opr_i & alu_2_opr_i;
            4'd8:  alu_res = product[XLEN-1:0];
            4'd9,
            4'd10,
            4'd11: alu_res = product[2*XLEN-1:XLEN];
            default: alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Iterative divider
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] div_rem_q, div_rem_d;
    logic [XLEN-1:0] div_quo_q, div_quo_d;  // dividend shifts out, quotient shifts in
    logic [XLEN-1:0] div_dsr_q, div_dsr_d;
    logic [XLEN-1:0] div_dnd_q, div_dnd_d;  // raw dividend for the special cases
    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic            div_unsigned_q, div_unsigned_d;
    logic            div_is_rem_q, div_is_rem_d;
    logic            div_neg_q_q, div_neg_q_d;
    logic            div_neg_r_q, div_neg_r_d;
    logic            div_zero_q, div_zero_d;
    logic            div_ovf_q, div_ovf_d;

    logic            a_neg;
    logic            b_neg;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   rem_diff;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] div_res;

    assign a_neg = ~alu_op_i[0] & alu_1_opr_i[XLEN-1];
    assign b_neg = ~alu_op_i[0] & alu_2_opr_i[XLEN-1];

    // Restoring step: subtract the divisor from the shifted partial remainder and
    // keep the difference only when it does not go negative.
    assign rem_shift = {div_rem_q, div_quo_q[XLEN-1]};
    assign rem_diff  = rem_shift - {1'b0, div_dsr_q};

    assign quo_fix = div_neg_q_q ? '0 - div_quo_q : div_quo_q;
    assign rem_fix = div_neg_r_q ? '0 - div_rem_q : div_rem_q;

    always_comb begin
        div_res = div_is_rem_q ? rem_fix : quo_fix;
        if (div_zero_q) begin
            div_res = div_is_rem_q ? div_dnd_q : '1;
        end else if (div_ovf_q) begin
            div_res = div_is_rem_q ? '0 : div_dnd_q;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM and EX/MEM register next state
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] alu_result_d;
    logic            reg_write_d;
    logic            mem_write_d;

    assign stall_o = rst_n && ((state_q == StBusy) || (state_q == StIdle && is_div));

    always_comb begin
        state_d        = state_q;
        div_rem_d      = div_rem_q;
        div_quo_d      = div_quo_q;
        div_dsr_d      = div_dsr_q;
        div_dnd_d      = div_dnd_q;
        div_cnt_d      = div_cnt_q;
        div_unsigned_d = div_unsigned_q;
        div_is_rem_d   = div_is_rem_q;
        div_neg_q_d    = div_neg_q_q;
        div_neg_r_d    = div_neg_r_q;
        div_zero_d     = div_zero_q;
        div_ovf_d      = div_ovf_q;
        alu_result_d   = alu_res;
        reg_write_d    = reg_write_i;
        mem_write_d    = mem_write_i;

        unique case (state_q)
            StIdle: begin
                if (is_div) begin
                    state_d        = StBusy;
                    div_rem_d      = '0;
                    div_quo_d      = a_neg ? '0 - alu_1_opr_i : alu_1_opr_i;
                    div_dsr_d      = b_neg ? '0 - alu_2_opr_i : alu_2_opr_i;
                    div_dnd_d      = alu_1_opr_i;
                    div_cnt_d      = '0;
                    div_unsigned_d = alu_op_i[0];
                    div_is_rem_d   = alu_op_i[1];
                    div_neg_q_d    = a_neg ^ b_neg;
                    div_neg_r_d    = a_neg;
                    div_zero_d     = (alu_2_opr_i == '0);
                    div_ovf_d      = ~alu_op_i[0]
                                     && (alu_1_opr_i == {1'b1, {(XLEN-1){1'b0}}})
                                     && (alu_2_opr_i == '1);
                    alu_result_d   = '0;
                    reg_write_d    = 1'b0;
                    mem_write_d    = 1'b0;
                end
            end
            StBusy: begin
                if (!rem_diff[XLEN]) begin
                    div_rem_d = rem_diff[XLEN-1:0];
                    div_quo_d = {div_quo_q[XLEN-2:0], 1'b1};
                end else begin
                    div_rem_d = rem_shift[XLEN-1:0];
                    div_quo_d = {div_quo_q[XLEN-2:0], 1'b0};
                end
                div_cnt_d = div_cnt_q + 1'b1;
                if (div_cnt_q == CntW'(XLEN - 1)) begin
                    state_d = StDone;
                end
                alu_result_d = '0;
                reg_write_d  = 1'b0;
                mem_write_d  = 1'b0;
            end
            StDone: begin
                // Upstream advances on this edge, so the held fields still belong
                // to the divide.
                state_d      = StIdle;
                alu_result_d = div_res;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q               <= StIdle;
            div_rem_q             <= '0;
            div_quo_q             <= '0;
            div_dsr_q             <= '0;
            div_dnd_q             <= '0;
            div_cnt_q             <= '0;
            div_unsigned_q        <= 1'b0;
            div_is_rem_q          <= 1'b0;
            div_neg_q_q           <= 1'b0;
            div_neg_r_q           <= 1'b0;
            div_zero_q            <= 1'b0;
            div_ovf_q             <= 1'b0;
            alu_result_o          <= '0;
            advance_pc_o          <= '0;
            reg_2_data_o          <= '0;
            reg_write_o           <= 1'b0;
            reg_write_data_addr_o <= '0;
            mem_write_o           <= 1'b0;
            mem_width_o           <= '0;
            mem_sign_extend_o     <= 1'b0;
            reg_src_o             <= '0;
        end else begin
            state_q               <= state_d;
            div_rem_q             <= div_rem_d;
            div_quo_q             <= div_quo_d;
            div_dsr_q             <= div_dsr_d;
            div_dnd_q             <= div_dnd_d;
            div_cnt_q             <= div_cnt_d;
            div_unsigned_q        <= div_unsigned_d;
            div_is_rem_q          <= div_is_rem_d;
            div_neg_q_q           <= div_neg_q_d;
            div_neg_r_q           <= div_neg_r_d;
            div_zero_q            <= div_zero_d;
            div_ovf_q             <= div_ovf_d;
            alu_result_o          <= alu_result_d;
            advance_pc_o          <= advance_pc_i;
            reg_2_data_o          <= reg_2_data_i;
            reg_write_o           <= reg_write_d;
            reg_write_data_addr_o <= reg_write_data_addr_i;
            mem_write_o           <= mem_write_d;
            mem_width_o           <= mem_width_i;
            mem_sign_extend_o     <= mem_sign_extend_i;
            reg_src_o             <= reg_src_i;
        end
    end

    // The sign mode is folded into the latched magnitudes; keep it for debug visibility.
    logic unused_div_unsigned;
    assign unused_div_unsigned = div_unsigned_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed spec vectors, randomized ALU and divide
// ops against a plain-arithmetic reference model, back-to-back and mid-divide reset.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] alu_1_opr_i = '0;
    logic [31:0] alu_2_opr_i = '0;
    logic [3:0]  alu_op_i = '0;
    logic        alu_flag_i = 1'b0;
    logic [31:0] advance_pc_i = '0;
    logic [31:0] reg_2_data_i = '0;
    logic        reg_write_i = 1'b0;
    logic [4:0]  reg_write_data_addr_i = '0;
    logic        mem_write_i = 1'b0;
    logic [1:0]  mem_width_i = '0;
    logic        mem_sign_extend_i = 1'b0;
    logic [1:0]  reg_src_i = '0;
    logic        stall_o;
    logic [31:0] alu_result_o;
    logic [31:0] advance_pc_o;
    logic [31:0] reg_2_data_o;
    logic        reg_write_o;
    logic [4:0]  reg_write_data_addr_o;
    logic        mem_write_o;
    logic [1:0]  mem_width_o;
    logic        mem_sign_extend_o;
    logic [1:0]  reg_src_o;

    int total = 0;
    int bad = 0;

    ex_stage #(.XLEN(32)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .alu_1_opr_i           (alu_1_opr_i),
        .alu_2_opr_i           (alu_2_opr_i),
        .alu_op_i              (alu_op_i),
        .alu_flag_i            (alu_flag_i),
        .advance_pc_i          (advance_pc_i),
        .reg_2_data_i          (reg_2_data_i),
        .reg_write_i           (reg_write_i),
        .reg_write_data_addr_i (reg_write_data_addr_i),
        .mem_write_i           (mem_write_i),
        .mem_width_i           (mem_width_i),
        .mem_sign_extend_i     (mem_sign_extend_i),
        .reg_src_i             (reg_src_i),
        .stall_o               (stall_o),
        .alu_result_o          (alu_result_o),
        .advance_pc_o          (advance_pc_o),
        .reg_2_data_o          (reg_2_data_o),
        .reg_write_o           (reg_write_o),
        .reg_write_data_addr_o (reg_write_data_addr_o),
        .mem_write_o           (mem_write_o),
        .mem_width_o           (mem_width_o),
        .mem_sign_extend_o     (mem_sign_extend_o),
        .reg_src_o             (reg_src_o)
    );

    always #5 clk = ~clk;

    // Reference model straight from the RV32IM definitions.
    function automatic logic [31:0] model(input logic [3:0] op, input logic flag,
                                          input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, ps;
        longint unsigned ua, ub, pu;
        logic [4:0]      sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        sh = b[4:0];
        case (op)
            4'd0:  return flag ? a - b : a + b;
            4'd1:  return a << sh;
            4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd3:  return (ua < ub) ? 32'd1 : 32'd0;
            4'd4:  return a ^ b;
            4'd5:  return flag ? 32'($signed(a) >>> sh) : a >> sh;
            4'd6:  return a | b;
            4'd7:  return a & b;
            4'd8:  begin pu = ua * ub; return pu[31:0]; end
            4'd9:  begin ps = sa * sb; return ps[63:32]; end
            4'd10: begin ps = sa * longint'(ub); return ps[63:32]; end
            4'd11: begin pu = ua * ub; return pu[63:32]; end
            4'd12: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            4'd13: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            4'd14: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] op, input logic flag,
                             input logic [31:0] a, input logic [31:0] b);
        alu_op_i              = op;
        alu_flag_i            = flag;
        alu_1_opr_i           = a;
        alu_2_opr_i           = b;
        advance_pc_i          = $urandom | 32'h1;
        reg_2_data_i          = $urandom;
        reg_write_data_addr_i = 5'($urandom);
        mem_width_i           = 2'($urandom);
        mem_sign_extend_i     = 1'($urandom);
        reg_src_i             = 2'($urandom);
        reg_write_i           = 1'b1;
        mem_write_i           = 1'b0;
    endtask

    task automatic test_reset();
        set_instr(4'd12, 1'b0, 32'd50, 32'd7);
        rst_n = 1'b0;
        #1;
        total++;
        if (stall_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_stall: got %b want 0", stall_o);
        end
        step();
        step();
        total++;
        if (alu_result_o !== 32'd0 || reg_write_o !== 1'b0 || advance_pc_o !== 32'd0 ||
            mem_write_o !== 1'b0 || reg_src_o !== 2'd0) begin
            bad++;
            $display("FAIL reset_outputs: res=%h rw=%b pc=%h mw=%b src=%h want all 0",
                     alu_result_o, reg_write_o, advance_pc_o, mem_write_o, reg_src_o);
        end
        set_instr(4'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic check_alu(input string name, input logic [3:0] op, input logic flag,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp);
        logic [31:0] pc;
        logic        rw;
        logic        mw;
        logic [4:0]  rd;
        set_instr(op, flag, a, b);
        reg_write_i = 1'($urandom);
        mem_write_i = 1'($urandom);
        pc = advance_pc_i;
        rw = reg_write_i;
        mw = mem_write_i;
        rd = reg_write_data_addr_i;
        #1;
        total++;
        if (stall_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_stall: got %b want 0", name, stall_o);
        end
        step();
        total++;
        if (alu_result_o !== exp) begin
            bad++;
            $display("FAIL %s_result: got %h want %h", name, alu_result_o, exp);
        end
        total++;
        if (advance_pc_o !== pc || reg_write_o !== rw || mem_write_o !== mw ||
            reg_write_data_addr_o !== rd) begin
            bad++;
            $display("FAIL %s_fields: pc=%h rw=%b mw=%b rd=%0d want pc=%h rw=%b mw=%b rd=%0d",
                     name, advance_pc_o, reg_write_o, mem_write_o, reg_write_data_addr_o,
                     pc, rw, mw, rd);
        end
    endtask

    task automatic run_div(input string name, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int          cnt;
        int          bubble_bad;
        logic [31:0] pc;
        set_instr(op, 1'b0, a, b);
        pc = advance_pc_i;
        cnt = 0;
        bubble_bad = 0;
        #1;
        while (stall_o === 1'b1 && cnt < 100) begin
            if (cnt >= 1 && (reg_write_o !== 1'b0 || mem_write_o !== 1'b0)) bubble_bad++;
            cnt++;
            step();
        end
        total++;
        if (cnt != 33) begin
            bad++;
            $display("FAIL %s_stall_cycles: got %0d want 33", name, cnt);
        end
        total++;
        if (bubble_bad != 0) begin
            bad++;
            $display("FAIL %s_bubble: %0d stalled cycles had a write enable, want 0",
                     name, bubble_bad);
        end
        total++;
        if (reg_write_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_early_write: got rw=%b want 0 before result", name, reg_write_o);
        end
        step();
        total++;
        if (alu_result_o !== exp || reg_write_o !== 1'b1 || advance_pc_o !== pc) begin
            bad++;
            $display("FAIL %s_result: got %h rw=%b pc=%h want %h rw=1 pc=%h",
                     name, alu_result_o, reg_write_o, advance_pc_o, exp, pc);
        end
    endtask

    task automatic test_alu_directed();
        check_alu("add", 4'd0, 1'b0, 32'd5, 32'd7, 32'd12);
        check_alu("sub", 4'd0, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE);
        check_alu("sra", 4'd5, 1'b1, 32'h8000_0000, 32'h24, 32'hF800_0000);
        check_alu("sltu", 4'd3, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd1);
        check_alu("mulhu", 4'd11, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    endtask

    task automatic test_alu_random();
        logic [3:0]  op;
        logic        flag;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 11));
            flag = 1'($urandom);
            a = $urandom;
            b = $urandom;
            if (i % 5 == 0) a = 32'h8000_0000;
            check_alu("alu_rand", op, flag, a, b, model(op, flag, a, b));
        end
    endtask

    task automatic test_div_directed();
        run_div("div_neg", 4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_div("rem_neg", 4'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_div("divu_zero", 4'd13, 32'd9, 32'd0, 32'hFFFF_FFFF);
        run_div("remu_zero", 4'd15, 32'd9, 32'd0, 32'd9);
        run_div("div_ovf", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_div("rem_ovf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    endtask

    task automatic test_div_random();
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 12; i++) begin
            op = 4'($urandom_range(12, 15));
            a = $urandom;
            case (i % 4)
                0: b = $urandom_range(1, 20);
                1: b = 32'd0 - 32'($urandom_range(1, 20));
                2: b = $urandom;
                default: b = (i == 3) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            endcase
            run_div("div_rand", op, a, b, model(op, 1'b0, a, b));
        end
    endtask

    task automatic test_back_to_back();
        run_div("b2b_div0", 4'd12, 32'd1000, 32'd7, 32'd142);
        check_alu("b2b_add", 4'd0, 1'b0, 32'd3, 32'd4, 32'd7);
        run_div("b2b_div1", 4'd13, 32'd77, 32'd5, 32'd15);
        run_div("b2b_div2", 4'd15, 32'd77, 32'd5, 32'd2);
    endtask

    task automatic test_reset_mid_div();
        set_instr(4'd12, 1'b0, 32'h1234_5678, 32'd3);
        for (int i = 0; i < 11; i++) step();
        total++;
        if (stall_o !== 1'b1 || advance_pc_o === 32'd0) begin
            bad++;
            $display("FAIL midrst_pre: stall=%b pc=%h want stall=1 pc!=0",
                     stall_o, advance_pc_o);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (stall_o !== 1'b0 || alu_result_o !== 32'd0 || advance_pc_o !== 32'd0 ||
            reg_2_data_o !== 32'd0 || reg_write_o !== 1'b0) begin
            bad++;
            $display("FAIL midrst_async: stall=%b res=%h pc=%h d=%h rw=%b want all 0",
                     stall_o, alu_result_o, advance_pc_o, reg_2_data_o, reg_write_o);
        end
        set_instr(4'd0, 1'b0, 32'd1, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_div("midrst_fresh", 4'd12, 32'd100, 32'd10, 32'd10);
    endtask

    initial begin
        test_reset();
        test_alu_directed();
        test_alu_random();
        test_div_directed();
        test_div_random();
        test_back_to_back();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
